// File: rtl/period_meter_pkg.sv
// Shared types and default sizing for the period meter.
// Imported by the meter top and its synchroniser.
package period_meter_pkg;

  localparam int unsigned CNT_WIDTH_DEF   = 24;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    STALLED    = 2'd2
  } pm_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser with a registered rising-edge strobe.
// Reusable for any slow asynchronous level such as a button.
module sync_edge_detect
  import period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic s,
  output logic edge_strobe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   p_q;
  logic                   p_d;
  logic                   strobe_q;
  logic                   strobe_d;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
    p_d      = sync_q[SYNC_STAGES-1];
    strobe_d = sync_q[SYNC_STAGES-1] & ~p_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      p_q      <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      p_q      <= p_d;
      strobe_q <= strobe_d;
    end
  end

  assign s           = sync_q[SYNC_STAGES-1];
  assign edge_strobe = strobe_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave
// in system clock cycles, flagging a stall when edges stop arriving.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sig_in,
  output logic                 edge_strobe,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 period_valid,
  output logic                 stalled
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 s;
  logic                 strobe;
  logic                 lvl_q;
  logic                 lvl_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] hcnt_q;
  logic [CNT_WIDTH-1:0] hcnt_d;

  pm_state_e            state_q;
  logic [CNT_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] high_time_q;
  logic                 period_valid_q;
  logic                 stalled_q;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .s          (s),
    .edge_strobe(strobe)
  );

  // The strobe lags s by one cycle, so the high-time counter samples
  // the equally delayed level to cover exactly rise..next-rise.
  always_comb begin
    lvl_d  = s;
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    if (strobe) begin
      cnt_d  = CNT_ONE;
      hcnt_d = CNT_ONE;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (lvl_q && (hcnt_q != CNT_MAX)) begin
        hcnt_d = hcnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q  <= 1'b0;
      cnt_q  <= '0;
      hcnt_q <= '0;
    end else begin
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= WAIT_FIRST;
      period_q       <= '0;
      high_time_q    <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      unique case (state_q)
        WAIT_FIRST: begin
          if (strobe) begin
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (strobe) begin
            period_q       <= cnt_q;
            high_time_q    <= hcnt_q;
            period_valid_q <= 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            state_q   <= STALLED;
            stalled_q <= 1'b1;
          end
        end
        STALLED: begin
          if (strobe) begin
            state_q   <= MEASURE;
            stalled_q <= 1'b0;
          end
        end
        default: begin
          state_q <= WAIT_FIRST;
        end
      endcase
    end
  end

  assign edge_strobe  = strobe;
  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign stalled      = stalled_q;

endmodule

// File: tb/tb_period_meter.sv
// Random and directed stimulus for two meter widths, checked per
// cycle against an edge-timestamp reference model.
module tb_period_meter;

  localparam int N = 8000;

  logic        clk = 1'b0;
  logic        reset;
  logic        sig_in;

  logic        str24, val24, st24;
  logic [23:0] p24, h24;
  logic        str4, val4, st4;
  logic [3:0]  p4, h4;

  always #5 clk = ~clk;

  period_meter u_dut24 (
    .clk         (clk),
    .reset       (reset),
    .sig_in      (sig_in),
    .edge_strobe (str24),
    .period      (p24),
    .high_time   (h24),
    .period_valid(val24),
    .stalled     (st24)
  );

  period_meter #(
    .CNT_WIDTH  (4),
    .SYNC_STAGES(2)
  ) u_dut4 (
    .clk         (clk),
    .reset       (reset),
    .sig_in      (sig_in),
    .edge_strobe (str4),
    .period      (p4),
    .high_time   (h4),
    .period_valid(val4),
    .stalled     (st4)
  );

  // Model: timestamps of sampled rises; outputs scheduled by edge index.
  int          max_c [2] = '{16777215, 15};
  bit          samp  [N];
  bit          e_str [2][N];
  bit          e_upd [2][N];
  int          e_per [2][N];
  int          e_ht  [2][N];
  bit          e_set [2][N];
  bit          e_clr [2][N];
  bit          e_rst [2][N];
  int          mode  [2];
  int          kl    [2];
  bit          prev;
  int          hold_p[2];
  int          hold_h[2];
  bit          hold_s[2];
  int          e;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               tag, got, exp, e);
    end
  endtask

  task automatic model_edge(int n, bit s_in, bit rst);
    bit rise;
    int ht;
    if (rst) begin
      prev    = 1'b0;
      samp[n] = 1'b0;
      for (int u = 0; u < 2; u++) begin
        mode[u] = 0;
        for (int i = n; i < N; i++) begin
          e_str[u][i] = 0;
          e_upd[u][i] = 0;
          e_set[u][i] = 0;
          e_clr[u][i] = 0;
          e_rst[u][i] = 0;
        end
        e_rst[u][n] = 1;
      end
      return;
    end
    samp[n] = s_in;
    rise    = s_in && !prev;
    prev    = s_in;
    for (int u = 0; u < 2; u++) begin
      if (rise) begin
        e_str[u][n+2] = 1;
        if (mode[u] == 1) begin
          ht = 0;
          for (int i = kl[u]; i < n; i++) ht += int'(samp[i]);
          e_upd[u][n+3] = 1;
          e_per[u][n+3] = n - kl[u];
          e_ht[u][n+3]  = ht;
        end else if (mode[u] == 2) begin
          e_clr[u][n+3] = 1;
        end
        mode[u] = 1;
        kl[u]   = n;
      end else if (mode[u] == 1 && (n - kl[u]) == max_c[u]) begin
        mode[u]       = 2;
        e_set[u][n+3] = 1;
      end
    end
  endtask

  task automatic check_edge();
    logic        o_str, o_val, o_st;
    logic [31:0] o_p, o_h;
    for (int u = 0; u < 2; u++) begin
      if (e_rst[u][e]) begin
        hold_p[u] = 0;
        hold_h[u] = 0;
        hold_s[u] = 0;
      end else begin
        if (e_upd[u][e]) begin
          hold_p[u] = e_per[u][e];
          hold_h[u] = e_ht[u][e];
        end
        if (e_set[u][e]) hold_s[u] = 1;
        if (e_clr[u][e]) hold_s[u] = 0;
      end
      if (u == 0) begin
        o_str = str24; o_val = val24; o_st = st24;
        o_p = {8'd0, p24}; o_h = {8'd0, h24};
      end else begin
        o_str = str4; o_val = val4; o_st = st4;
        o_p = {28'd0, p4}; o_h = {28'd0, h4};
      end
      chk($sformatf("u%0d_strobe", u), {31'd0, o_str},
          {31'd0, e_str[u][e] & ~e_rst[u][e]});
      chk($sformatf("u%0d_valid", u), {31'd0, o_val},
          {31'd0, e_upd[u][e] & ~e_rst[u][e]});
      chk($sformatf("u%0d_period", u), o_p, hold_p[u]);
      chk($sformatf("u%0d_high", u), o_h, hold_h[u]);
      chk($sformatf("u%0d_stalled", u), {31'd0, o_st},
          {31'd0, hold_s[u]});
    end
  endtask

  task automatic step(bit s_in, bit rst);
    @(negedge clk);
    check_edge();
    if (e + 4 >= N) begin
      $display("FAIL edge_budget: got %0d expected below %0d", e, N - 4);
      $fatal(1);
    end
    sig_in = s_in;
    reset  = rst;
    model_edge(e + 1, s_in, rst);
    e++;
  endtask

  task automatic seg(int hi, int lo);
    repeat (hi) step(1'b1, 1'b0);
    repeat (lo) step(1'b0, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    prev   = 1'b0;
    for (int u = 0; u < 2; u++) begin
      mode[u] = 0; kl[u] = 0;
      hold_p[u] = 0; hold_h[u] = 0; hold_s[u] = 0;
    end
    e = 0;
    model_edge(1, 1'b0, 1'b1);
    e = 1;

    repeat (3) step(1'b0, 1'b1);
    repeat (50) step(1'b0, 1'b0);
    chk("idle_period", {8'd0, p24}, 0);
    chk("idle_stalled", {31'd0, st4}, 0);

    repeat (4) seg(5, 5);
    chk("sq55_period", {8'd0, p24}, 10);
    chk("sq55_high", {8'd0, h24}, 5);

    repeat (4) seg(3, 7);
    chk("sq37_high", {8'd0, h24}, 3);
    repeat (4) seg(2, 2);
    repeat (2) step(1'b0, 1'b0);
    chk("sq22_period", {8'd0, p24}, 4);
    chk("sq22_high", {28'd0, h4}, 2);

    repeat (8) seg(1, 1);
    repeat (2) step(1'b0, 1'b0);
    chk("tog_period", {8'd0, p24}, 2);
    chk("tog_high", {8'd0, h24}, 1);

    repeat (40) step(1'b0, 1'b0);
    chk("stall_w4", {31'd0, st4}, 1);
    chk("stall_w24", {31'd0, st24}, 0);
    chk("stall_holds", {28'd0, p4}, 2);
    seg(4, 4);
    seg(4, 4);
    chk("after_stall", {28'd0, p4}, 8);
    repeat (4) seg(5, 10);
    chk("gap15_period", {28'd0, p4}, 15);
    chk("gap15_stalled", {31'd0, st4}, 0);

    repeat (2) seg(6, 6);
    seg(6, 3);
    step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    repeat (3) seg(6, 6);
    chk("rst_mid_period", {8'd0, p24}, 12);
    chk("rst_mid_high", {8'd0, h24}, 6);

    for (int i = 0; i < 40; i++) begin
      int hi, lo;
      hi = int'($urandom_range(1, 12));
      lo = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 20))
                                       : int'($urandom_range(1, 12));
      seg(hi, lo);
      if ($urandom_range(0, 9) == 0) step(sig_in, 1'b1);
    end
    repeat (20) step(1'b0, 1'b0);
    @(negedge clk);
    check_edge();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
